uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9, giving bits per frame after the start bit (8 data + 1 stop).
REQ-002 SHALL have parameter BAUD_DIV, default 434, giving clk cycles per serial bit; legal range 4..65535.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port shift_en, output, 1, one-cycle strobe that loads shift_d into the downstream right shift register.
REQ-007 SHALL have port shift_d, output, 1, the sampled bit value, valid whenever shift_en=1.
REQ-008 SHALL have port rx_done, output, 1, one-cycle pulse marking that a full frame has been shifted out.
REQ-009 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-010 SHALL have port frame_err, output, 1, registered stop-bit error flag.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer to form rx_s; all decisions use rx_s only.
REQ-012 SHALL implement FSM states IDLE, START, SHIFT, DONE.
REQ-013 IDLE: rx_s=0 -> START, with baud counter cleared to 0.
REQ-014 START: counter increments each cycle; at count BAUD_DIV/2-1 (integer division): rx_s=0 -> SHIFT with counter and bit_cnt cleared; rx_s=1 -> IDLE (false start, no strobe).
REQ-015 SHIFT: counter increments each cycle; at count BAUD_DIV-1 -> shift_en=1 for that cycle, shift_d=rx_s, counter cleared, bit_cnt incremented.
REQ-016 SHIFT: the strobe with bit_cnt=DATA_WIDTH-1 -> DONE.
REQ-017 DONE: lasts exactly one cycle with rx_done=1, then -> IDLE.
REQ-018 SHALL emit exactly DATA_WIDTH shift_en strobes per accepted frame and none outside SHIFT.
REQ-019 frame_err SHALL be loaded in DONE with the inverse of the last shifted bit (stop bit = 0 -> 1) and held until the next DONE.
REQ-020 A low rx_s in IDLE in the same cycle DONE exits SHALL be detected on the following cycle; no frames are lost back-to-back.
REQ-021 rx activity during SHIFT other than at sample points SHALL be ignored.
REQ-022 Counter width SHALL be $clog2(BAUD_DIV); bit_cnt width SHALL be $clog2(DATA_WIDTH+1); neither wraps within a frame.
REQ-023 The start-edge-to-first-strobe latency SHALL be 2 sync cycles + BAUD_DIV/2 + BAUD_DIV cycles (±1).

Reset
REQ-024 rst=1 at a clk edge SHALL force IDLE, clear counter and bit_cnt, and set shift_en=0, shift_d=0, rx_done=0, busy=0, frame_err=0, with synchronizer flops set to 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no further strobes; reception resumes on the next falling edge of rx_s after rst=0.

Configuration
REQ-026 Macro UART_RX_GLITCH_FILTER_EN defined: the value used as rx_s SHALL be the 3-sample majority of the last three synchronizer outputs, adding 1 cycle of latency to REQ-023.
REQ-027 Macro UART_RX_GLITCH_FILTER_EN undefined: rx_s SHALL be the synchronizer output directly, with no filter logic.

Verification
REQ-028 BAUD_DIV=8, DATA_WIDTH=9, send 0xA5 LSB-first plus stop=1 -> 9 strobes with shift_d sequence 1,0,1,0,0,1,0,1,1; downstream Q=9'h1A5; rx_done pulses once; frame_err=0.
REQ-029 Same frame with stop=0 -> Q=9'h0A5, rx_done pulses, frame_err=1 and held until the next frame's DONE.
REQ-030 rx low for 2 cycles only (BAUD_DIV=8) -> FSM returns to IDLE from START; 0 strobes; rx_done=0.
REQ-031 Two frames 0x3C then 0xC3 back-to-back, no idle gap -> 18 strobes and 2 rx_done pulses; Q=9'h13C, then 9'h1C3.
REQ-032 rst=1 after the 4th strobe -> all outputs at reset values on the next edge; no further strobes; the next frame 0x5A is received correctly.
REQ-033 With UART_RX_GLITCH_FILTER_EN defined, a 1-cycle low glitch on rx at the data-bit midpoint -> the sampled bit is unchanged and the strobe appears 1 cycle later than without the macro.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: strobes each frame bit into a downstream shift register; UART_RX_GLITCH_FILTER_EN adds a 3-sample majority filter.
// Latency: first strobe 2 + BAUD_DIV/2 + BAUD_DIV cycles after the start edge (+1 with the filter).
// Backpressure: none; the serial line cannot be stalled, so the downstream register must accept every strobe.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 9,
  parameter int BAUD_DIV   = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic shift_en,
  output logic shift_d,
  output logic rx_done,
  output logic busy,
  output logic frame_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_END = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic          sync1, sync2;
  logic          rx_s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic          last_bit;
  logic          sample;

  // Flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  logic hist1, hist2;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist1 <= 1'b1;
      hist2 <= 1'b1;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
    end
  end

  assign rx_s = (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
`else
  assign rx_s = sync2;
`endif

  assign sample    = (state == SHIFT) && (cnt == FULL_END);
  assign shift_en  = sample;
  assign shift_d   = sample & rx_s;
  assign rx_done   = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      last_bit  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // Re-check the line at mid start bit to reject short glitches.
          if (cnt == HALF_END) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? IDLE : SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (sample) begin
            cnt      <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
            last_bit <= rx_s;
            if (bit_cnt == LAST_BIT) state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          frame_err <= ~last_bit;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
